// File: rtl/pwr_domain_ctrl.sv
// pwr_domain_ctrl: multi-domain power manager for the low-speed I/O peripherals.
// Moves NUM_DOM clock-enable domains through ACTIVE/IDLE/SLEEP/OFF, using a
// quiesce handshake with timeout on the way down and a staggered domain
// re-enable on the way up.
// Optional build macro: PWR_STATS_EN adds a saturating wake counter and a
// saturating SLEEP/OFF cycle counter; without it both outputs read zero.
module pwr_domain_ctrl #(
  parameter int                 NUM_DOM       = 3,
  parameter int                 NUM_WAKE      = 4,
  parameter int                 CNT_W         = 16,
  parameter int                 IDLE_TIMEOUT  = 1000,
  parameter int                 DRAIN_TIMEOUT = 256,
  parameter int                 WAKE_STEP     = 4,
  parameter logic [NUM_DOM-1:0] IDLE_MASK     = NUM_DOM'(1),
  parameter logic [NUM_DOM-1:0] SLEEP_MASK    = NUM_DOM'(0)
) (
  input  logic                i_sys_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_pwr_req,
  input  logic                i_auto_idle_en,
  input  logic                i_activity,
  input  logic [NUM_WAKE-1:0] i_wake_src,
  input  logic [NUM_WAKE-1:0] i_wake_mask,
  output logic                o_quiesce_req,
  input  logic                i_quiesce_ack,
  output logic [NUM_DOM-1:0]  o_clk_en,
  output logic [1:0]          o_pwr_state,
  output logic                o_busy,
  output logic                o_wake_event,
  output logic [NUM_WAKE-1:0] o_wake_cause,
  output logic                o_drain_err,
  output logic                o_in_low_power,
  output logic [15:0]         o_wake_cnt,
  output logic [31:0]         o_sleep_cycles
);

  localparam logic [2:0] ST_ACTIVE = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_SLEEP  = 3'd3;
  localparam logic [2:0] ST_OFF    = 3'd4;
  localparam logic [2:0] ST_WAKE   = 3'd5;

  localparam logic [1:0] REQ_ACTIVE = 2'b00;
  localparam logic [1:0] REQ_IDLE   = 2'b01;
  localparam logic [1:0] REQ_SLEEP  = 2'b10;
  localparam logic [1:0] REQ_OFF    = 2'b11;

  localparam logic [CNT_W-1:0]   IDLE_LIM  = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0]   DRAIN_LIM = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STEP_LIM  = CNT_W'(WAKE_STEP - 1);
  localparam logic [NUM_DOM-1:0] ALL_ON    = '1;
  localparam logic [NUM_DOM-1:0] DOM0      = NUM_DOM'(1);
  localparam logic [3:0]         DOM_LAST  = 4'(NUM_DOM);

  logic [2:0]         state, state_nxt;
  logic [2:0]         target, target_nxt;
  logic [CNT_W-1:0]   idle_cnt;
  logic [CNT_W-1:0]   drain_cnt;
  logic [CNT_W-1:0]   step_cnt, step_cnt_nxt;
  logic [3:0]         dom_idx, dom_idx_nxt;
  logic [NUM_DOM-1:0] clk_en_nxt;
  logic [1:0]         pwr_state_nxt;
  logic               wake_hit;
  logic               idle_expired;
  logic               drain_timeout;
  logic               wake_entry;
  logic               wake_done;

  assign wake_hit     = |(i_wake_src & i_wake_mask);
  assign idle_expired = (idle_cnt == IDLE_LIM);
  assign wake_entry   = (state_nxt == ST_WAKE) && (state != ST_WAKE);
  assign wake_done    = (state == ST_WAKE) && (state_nxt == ST_ACTIVE);

  // State transitions: entry arbitration, drain handshake, wake decoding.
  always_comb begin
    state_nxt     = state;
    target_nxt    = target;
    drain_timeout = 1'b0;
    case (state)
      ST_ACTIVE: begin
        if (i_pwr_req == REQ_OFF) begin
          state_nxt  = ST_DRAIN;
          target_nxt = ST_OFF;
        end else if (i_pwr_req == REQ_SLEEP) begin
          state_nxt  = ST_DRAIN;
          target_nxt = ST_SLEEP;
        end else if (idle_expired && !i_activity &&
                     ((i_pwr_req == REQ_IDLE) || i_auto_idle_en)) begin
          state_nxt  = ST_DRAIN;
          target_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (i_quiesce_ack) begin
          state_nxt = target;
        end else if ((target == ST_IDLE) && i_activity) begin
          state_nxt = ST_ACTIVE;
        end else if (drain_cnt == DRAIN_LIM) begin
          state_nxt     = ST_ACTIVE;
          drain_timeout = 1'b1;
        end
      end
      ST_IDLE: begin
        if (i_activity || wake_hit || (i_pwr_req == REQ_ACTIVE)) begin
          state_nxt = ST_WAKE;
        end else if (i_pwr_req == REQ_SLEEP) begin
          state_nxt = ST_SLEEP;
        end else if (i_pwr_req == REQ_OFF) begin
          state_nxt = ST_OFF;
        end
      end
      ST_SLEEP: begin
        if (wake_hit || (i_pwr_req == REQ_ACTIVE)) begin
          state_nxt = ST_WAKE;
        end else if (i_pwr_req == REQ_OFF) begin
          state_nxt = ST_OFF;
        end
      end
      ST_OFF: begin
        if (i_pwr_req == REQ_ACTIVE) begin
          state_nxt = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (o_clk_en == ALL_ON) begin
          state_nxt = ST_ACTIVE;
        end
      end
      default: state_nxt = ST_ACTIVE;
    endcase
  end

  // Clock-enable pattern, staggered wake sequencing and reported power state.
  always_comb begin
    clk_en_nxt    = o_clk_en;
    step_cnt_nxt  = step_cnt;
    dom_idx_nxt   = dom_idx;
    pwr_state_nxt = o_pwr_state;
    case (state_nxt)
      ST_ACTIVE: begin
        clk_en_nxt    = ALL_ON;
        pwr_state_nxt = REQ_ACTIVE;
      end
      ST_DRAIN: pwr_state_nxt = REQ_ACTIVE;
      ST_IDLE: begin
        clk_en_nxt    = IDLE_MASK;
        pwr_state_nxt = REQ_IDLE;
      end
      ST_SLEEP: begin
        clk_en_nxt    = SLEEP_MASK;
        pwr_state_nxt = REQ_SLEEP;
      end
      ST_OFF: begin
        clk_en_nxt    = '0;
        pwr_state_nxt = REQ_OFF;
      end
      ST_WAKE: begin
        if (state != ST_WAKE) begin
          clk_en_nxt   = o_clk_en | DOM0;
          step_cnt_nxt = '0;
          dom_idx_nxt  = 4'd1;
        end else if (step_cnt == STEP_LIM) begin
          step_cnt_nxt = '0;
          if (dom_idx < DOM_LAST) begin
            clk_en_nxt  = o_clk_en | (DOM0 << dom_idx);
            dom_idx_nxt = dom_idx + 4'd1;
          end
        end else begin
          step_cnt_nxt = step_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Main state and registered outputs.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_ACTIVE;
      target         <= ST_ACTIVE;
      step_cnt       <= '0;
      dom_idx        <= '0;
      o_clk_en       <= ALL_ON;
      o_pwr_state    <= REQ_ACTIVE;
      o_busy         <= 1'b0;
      o_quiesce_req  <= 1'b0;
      o_in_low_power <= 1'b0;
      o_drain_err    <= 1'b0;
      o_wake_event   <= 1'b0;
      o_wake_cause   <= '0;
    end else begin
      state          <= state_nxt;
      target         <= target_nxt;
      step_cnt       <= step_cnt_nxt;
      dom_idx        <= dom_idx_nxt;
      o_clk_en       <= clk_en_nxt;
      o_pwr_state    <= pwr_state_nxt;
      o_busy         <= (state_nxt == ST_DRAIN) || (state_nxt == ST_WAKE);
      o_quiesce_req  <= (state_nxt == ST_DRAIN);
      o_in_low_power <= (state_nxt == ST_IDLE) || (state_nxt == ST_SLEEP) ||
                        (state_nxt == ST_OFF);
      o_drain_err    <= drain_timeout;
      o_wake_event   <= wake_done;
      if (wake_entry) begin
        o_wake_cause <= i_wake_src & i_wake_mask;
      end
    end
  end

  // Inactivity counter; only runs while staying in ACTIVE, so every return to ACTIVE starts from zero.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt <= '0;
    end else if ((state != ST_ACTIVE) || (state_nxt != ST_ACTIVE) || i_activity) begin
      idle_cnt <= '0;
    end else if (!idle_expired) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Drain age: cycles already spent waiting for the quiesce acknowledge.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drain_cnt <= '0;
    end else if ((state == ST_DRAIN) && (state_nxt == ST_DRAIN)) begin
      drain_cnt <= drain_cnt + CNT_W'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

`ifdef PWR_STATS_EN
  logic [15:0] wake_cnt;
  logic [31:0] sleep_cycles;

  // Saturating statistics, cleared only by reset.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wake_cnt     <= '0;
      sleep_cycles <= '0;
    end else begin
      if (wake_done && (wake_cnt != 16'hFFFF)) begin
        wake_cnt <= wake_cnt + 16'd1;
      end
      if (((state == ST_SLEEP) || (state == ST_OFF)) && (sleep_cycles != 32'hFFFF_FFFF)) begin
        sleep_cycles <= sleep_cycles + 32'd1;
      end
    end
  end

  assign o_wake_cnt     = wake_cnt;
  assign o_sleep_cycles = sleep_cycles;
`else
  assign o_wake_cnt     = '0;
  assign o_sleep_cycles = '0;
`endif

endmodule

// File: tb/tb_pwr_domain_ctrl.sv
// tb_pwr_domain_ctrl: directed scenarios followed by randomized traffic, all
// checked every cycle against a behavioural model of the power manager.
module tb_pwr_domain_ctrl;

  localparam int         NUM_DOM  = 3;
  localparam int         NUM_WAKE = 4;
  localparam int         IDLE_TO  = 8;
  localparam int         DRAIN_TO = 16;
  localparam int         STEP     = 4;
  localparam logic [2:0] IDLE_M   = 3'b001;
  localparam logic [2:0] SLEEP_M  = 3'b000;

  localparam int M_ACTIVE = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_IDLE   = 2;
  localparam int M_SLEEP  = 3;
  localparam int M_OFF    = 4;
  localparam int M_WAKE   = 5;

  logic        i_sys_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  i_pwr_req = 2'b00;
  logic        i_auto_idle_en = 1'b0;
  logic        i_activity = 1'b0;
  logic [3:0]  i_wake_src = 4'b0;
  logic [3:0]  i_wake_mask = 4'b0;
  logic        i_quiesce_ack = 1'b0;
  logic        o_quiesce_req;
  logic [2:0]  o_clk_en;
  logic [1:0]  o_pwr_state;
  logic        o_busy;
  logic        o_wake_event;
  logic [3:0]  o_wake_cause;
  logic        o_drain_err;
  logic        o_in_low_power;
  logic [15:0] o_wake_cnt;
  logic [31:0] o_sleep_cycles;

  always #5 i_sys_clk = ~i_sys_clk;

  pwr_domain_ctrl #(
    .NUM_DOM(NUM_DOM), .NUM_WAKE(NUM_WAKE), .CNT_W(16), .IDLE_TIMEOUT(IDLE_TO),
    .DRAIN_TIMEOUT(DRAIN_TO), .WAKE_STEP(STEP), .IDLE_MASK(IDLE_M), .SLEEP_MASK(SLEEP_M)
  ) dut (
    .i_sys_clk(i_sys_clk), .i_rst_n(i_rst_n), .i_pwr_req(i_pwr_req),
    .i_auto_idle_en(i_auto_idle_en), .i_activity(i_activity), .i_wake_src(i_wake_src),
    .i_wake_mask(i_wake_mask), .o_quiesce_req(o_quiesce_req), .i_quiesce_ack(i_quiesce_ack),
    .o_clk_en(o_clk_en), .o_pwr_state(o_pwr_state), .o_busy(o_busy),
    .o_wake_event(o_wake_event), .o_wake_cause(o_wake_cause), .o_drain_err(o_drain_err),
    .o_in_low_power(o_in_low_power), .o_wake_cnt(o_wake_cnt), .o_sleep_cycles(o_sleep_cycles)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: mode plus elapsed-time bookkeeping per phase.
  int          m_mode, m_target, m_idle, m_drain_age, m_wake_age;
  logic [2:0]  m_clk, m_base;
  logic [1:0]  m_pwr;
  logic [3:0]  m_cause;
  logic        m_evt, m_err;
  int unsigned m_wake_cnt;
  longint      m_sleep;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_ACTIVE; m_target = M_ACTIVE; m_idle = 0; m_drain_age = 0; m_wake_age = 0;
    m_clk = 3'b111; m_base = 3'b000; m_pwr = 2'b00; m_cause = 4'b0;
    m_evt = 1'b0; m_err = 1'b0; m_wake_cnt = 0; m_sleep = 0;
  endtask

  task automatic enter_active();
    m_mode = M_ACTIVE; m_clk = 3'b111; m_pwr = 2'b00; m_idle = 0;
  endtask

  task automatic enter_drain(input int t);
    m_mode = M_DRAIN; m_target = t; m_drain_age = 0;
  endtask

  task automatic enter_low(input int t);
    m_mode = t;
    if (t == M_IDLE) begin m_clk = IDLE_M; m_pwr = 2'b01; end
    else if (t == M_SLEEP) begin m_clk = SLEEP_M; m_pwr = 2'b10; end
    else begin m_clk = 3'b000; m_pwr = 2'b11; end
  endtask

  task automatic enter_wake();
    m_mode = M_WAKE; m_base = m_clk; m_wake_age = 0;
    m_cause = i_wake_src & i_wake_mask;
    m_clk = m_base | 3'b001;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic hit;
    int   en;
    hit = ((i_wake_src & i_wake_mask) != 4'b0);
    m_evt = 1'b0;
    m_err = 1'b0;
    if ((m_mode == M_SLEEP || m_mode == M_OFF) && m_sleep < 64'hFFFF_FFFF) m_sleep++;
    case (m_mode)
      M_ACTIVE: begin
        if (i_pwr_req == 2'b11) enter_drain(M_OFF);
        else if (i_pwr_req == 2'b10) enter_drain(M_SLEEP);
        else if (m_idle >= IDLE_TO && !i_activity && (i_pwr_req == 2'b01 || i_auto_idle_en))
          enter_drain(M_IDLE);
        else if (i_activity) m_idle = 0;
        else if (m_idle < IDLE_TO) m_idle++;
      end
      M_DRAIN: begin
        if (i_quiesce_ack) enter_low(m_target);
        else if (m_target == M_IDLE && i_activity) enter_active();
        else if (m_drain_age + 1 >= DRAIN_TO) begin enter_active(); m_err = 1'b1; end
        else m_drain_age++;
      end
      M_IDLE: begin
        if (i_activity || hit || i_pwr_req == 2'b00) enter_wake();
        else if (i_pwr_req == 2'b10) enter_low(M_SLEEP);
        else if (i_pwr_req == 2'b11) enter_low(M_OFF);
      end
      M_SLEEP: begin
        if (hit || i_pwr_req == 2'b00) enter_wake();
        else if (i_pwr_req == 2'b11) enter_low(M_OFF);
      end
      M_OFF: begin
        if (i_pwr_req == 2'b00) enter_wake();
      end
      default: begin
        if (m_clk == 3'b111) begin
          enter_active();
          m_evt = 1'b1;
          if (m_wake_cnt < 16'hFFFF) m_wake_cnt++;
        end else begin
          m_wake_age++;
          en = m_wake_age / STEP + 1;
          if (en > NUM_DOM) en = NUM_DOM;
          m_clk = m_base | 3'((1 << en) - 1);
        end
      end
    endcase
  endtask

  task automatic checkOutput();
    logic [31:0] exp_wc, exp_sc;
`ifdef PWR_STATS_EN
    exp_wc = m_wake_cnt;
    exp_sc = 32'(m_sleep);
`else
    exp_wc = 0;
    exp_sc = 0;
`endif
    cmp("clk_en", o_clk_en, m_clk);
    cmp("pwr_state", o_pwr_state, m_pwr);
    cmp("busy", o_busy, (m_mode == M_DRAIN || m_mode == M_WAKE));
    cmp("quiesce_req", o_quiesce_req, (m_mode == M_DRAIN));
    cmp("in_low_power", o_in_low_power, (m_mode == M_IDLE || m_mode == M_SLEEP || m_mode == M_OFF));
    cmp("wake_event", o_wake_event, m_evt);
    cmp("drain_err", o_drain_err, m_err);
    cmp("wake_cause", o_wake_cause, m_cause);
    cmp("wake_cnt", o_wake_cnt, exp_wc);
    cmp("sleep_cycles", o_sleep_cycles, exp_sc);
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic auto_en, input logic act,
                               input logic [3:0] src, input logic [3:0] mask, input logic ack);
    i_pwr_req = req; i_auto_idle_en = auto_en; i_activity = act;
    i_wake_src = src; i_wake_mask = mask; i_quiesce_ack = ack;
  endtask

  task automatic tick();
    @(posedge i_sys_clk);
    model_step();
    #1;
    checkOutput();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    i_rst_n = 1'b0;
    #2;
    model_reset();
    checkOutput();
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int ack_mode;
    logic [1:0] r_req;
    logic r_auto, r_act, r_ack;
    logic [3:0] r_src, r_mask;

    // Reset values
    model_reset();
    applyStimulus(2'b01, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    #12;
    checkOutput();
    cmp("reset_clk_en", o_clk_en, 3'b111);
    cmp("reset_pwr_state", o_pwr_state, 2'b00);
    #11;
    i_rst_n = 1'b1;

    // Idle request: drain after IDLE_TO quiet cycles, ack two cycles later
    cnt = 0;
    while (o_quiesce_req !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    cmp("drain_entry_cycle", cnt, IDLE_TO + 1);
    tick();
    tick();
    applyStimulus(2'b01, 1'b0, 1'b0, 4'b0, 4'b0, 1'b1);
    tick();
    cmp("idle_pwr_state", o_pwr_state, 2'b01);
    cmp("idle_clk_en", o_clk_en, 3'b001);

    // Activity wakes from IDLE with staggered domain enables
    applyStimulus(2'b01, 1'b0, 1'b1, 4'b0, 4'b0, 1'b0);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    cmp("wake0_clk_en", o_clk_en, 3'b001);
    cmp("wake0_busy", o_busy, 1'b1);
    repeat (STEP) tick();
    cmp("wake1_clk_en", o_clk_en, 3'b011);
    repeat (STEP) tick();
    cmp("wake2_clk_en", o_clk_en, 3'b111);
    tick();
    cmp("wake_event", o_wake_event, 1'b1);
    cmp("wake_cause_sw", o_wake_cause, 4'b0000);

    // Sleep request with no acknowledge: drain timeout
    applyStimulus(2'b10, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    repeat (DRAIN_TO - 1) tick();
    cmp("drain_err_early", o_drain_err, 1'b0);
    tick();
    cmp("drain_err_pulse", o_drain_err, 1'b1);
    cmp("drain_err_clk_en", o_clk_en, 3'b111);
    cmp("drain_err_pwr_state", o_pwr_state, 2'b00);

    // SLEEP with masked wake sources
    applyStimulus(2'b10, 1'b0, 1'b0, 4'b0000, 4'b0101, 1'b1);
    tick();
    tick();
    cmp("sleep_pwr_state", o_pwr_state, 2'b10);
    cmp("sleep_clk_en", o_clk_en, 3'b000);
    applyStimulus(2'b10, 1'b0, 1'b0, 4'b1010, 4'b0101, 1'b0);
    repeat (3) tick();
    cmp("sleep_masked_hold", o_pwr_state, 2'b10);
    applyStimulus(2'b10, 1'b0, 1'b0, 4'b0110, 4'b0101, 1'b0);
    tick();
    cmp("sleep_wake_cause", o_wake_cause, 4'b0100);
    cmp("sleep_wake_busy", o_busy, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b0, 4'b0000, 4'b0101, 1'b0);
    cnt = 0;
    while (o_wake_event !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    cmp("sleep_wake_done", o_wake_event, 1'b1);

    // OFF ignores wake sources and activity
    applyStimulus(2'b11, 1'b0, 1'b0, 4'b0, 4'b0, 1'b1);
    tick();
    tick();
    applyStimulus(2'b11, 1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0);
    repeat (3) tick();
    cmp("off_pwr_state", o_pwr_state, 2'b11);
    cmp("off_clk_en", o_clk_en, 3'b000);
    applyStimulus(2'b00, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    cmp("off_wake_busy", o_busy, 1'b1);
    cnt = 0;
    while (o_wake_event !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    cmp("off_wake_done", o_wake_event, 1'b1);
`ifdef PWR_STATS_EN
    cmp("wake_cnt_total", o_wake_cnt, 16'd3);
`endif

    // Reset mid-WAKE after domain 0 is enabled
    applyStimulus(2'b11, 1'b0, 1'b0, 4'b0, 4'b0, 1'b1);
    tick();
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    tick();
    i_rst_n = 1'b0;
    #2;
    cmp("rst_wake_clk_en", o_clk_en, 3'b111);
    cmp("rst_wake_busy", o_busy, 1'b0);
    cmp("rst_wake_pwr_state", o_pwr_state, 2'b00);
    model_reset();
    checkOutput();
    #1;
    i_rst_n = 1'b1;

    // Randomized traffic against the model
    r_req = 2'b00; r_auto = 1'b0; r_act = 1'b0; r_ack = 1'b0;
    r_src = 4'b0; r_mask = 4'b1111; ack_mode = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 32 == 0) ack_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) r_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) r_auto = ~r_auto;
      if ($urandom_range(0, 31) == 0) r_mask = 4'($urandom_range(0, 15));
      r_act = ($urandom_range(0, 11) == 0);
      r_src = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      r_ack = (ack_mode == 2) || (ack_mode == 1 && $urandom_range(0, 3) == 0);
      applyStimulus(r_req, r_auto, r_act, r_src, r_mask, r_ack);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
